// File: rtl/arb_request_issuer.sv
// arb_request_issuer: per-channel pending counters feeding a fixed-order arbiter; optional grant checker under ARB_REQ_ISSUER_GRANT_CHECK_EN
module arb_request_issuer #(
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] evt,
  output logic [3:0] req,
  input  logic [3:0] grant,
  output logic [3:0] served,
  output logic [3:0] overflow,
  output logic       grant_err
);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [3:0] in_req;
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : ch
      state_t st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic acc, drop, inc, req_q, srv_q, ovf_q;
      assign in_req[g] = st_q == REQ;
      assign acc  = grant[g] & in_req[g];
      assign drop = evt[g] & (cnt_q == MAX) & ~acc;
      assign inc  = evt[g] & ~drop;
      // counter nets increment against accepted grant; state leaves GAP after one cycle
      always_comb begin
        cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(acc);
        st_d  = in_req[g] ? (acc ? GAP : REQ) : (cnt_d != '0 ? REQ : IDLE);
      end
      // channel state, counter and registered outputs
      always_ff @(posedge clk) begin
        if (rst) begin
          st_q  <= IDLE;
          cnt_q <= '0;
          req_q <= 1'b0;
          srv_q <= 1'b0;
          ovf_q <= 1'b0;
        end else begin
          st_q  <= st_d;
          cnt_q <= cnt_d;
          req_q <= st_d == REQ;
          srv_q <= acc;
          ovf_q <= ovf_q | drop;
        end
      end
      assign req[g]      = req_q;
      assign served[g]   = srv_q;
      assign overflow[g] = ovf_q;
    end
  endgenerate
`ifdef ARB_REQ_ISSUER_GRANT_CHECK_EN
  // sticky flag for grants to non-requesting channels or multi-hot grants
  always_ff @(posedge clk) begin
    if (rst) grant_err <= 1'b0;
    else if (|(grant & ~in_req) || (grant & (grant - 4'd1)) != 4'd0) grant_err <= 1'b1;
  end
`else
  assign grant_err = 1'b0;
`endif
endmodule

// File: tb/tb_arb_request_issuer.sv
// tb_arb_request_issuer: directed vector table plus overflow and reset sequences
module tb_arb_request_issuer;
`ifdef ARB_REQ_ISSUER_GRANT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, grant_err;
  logic [3:0] evt = '0, grant = '0, req, served, overflow;
  int checks = 0, errors = 0;

  arb_request_issuer dut (
    .clk(clk), .rst(rst), .evt(evt), .req(req), .grant(grant),
    .served(served), .overflow(overflow), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic [3:0] e, g, rq, sv, ov;
    logic er;
  } vec_t;

  task automatic step(input logic r, input logic [3:0] e, input logic [3:0] g);
    @(negedge clk);
    rst = r; evt = e; grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  vec_t v[17];

  initial begin
    v[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    v[1]  = '{1'b0, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1'b0};
    v[2]  = '{1'b0, 4'b0000, 4'b0001, 4'b1010, 4'b0001, 4'b0000, 1'b0};
    v[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0};
    v[4]  = '{1'b0, 4'b1000, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 1'b0};
    v[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0};
    v[6]  = '{1'b0, 4'b0000, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 1'b0};
    v[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    v[8]  = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    v[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    v[10] = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, CHK};
    v[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, CHK};
    v[12] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    v[13] = '{1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 1'b0};
    v[14] = '{1'b0, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000, CHK};
    v[15] = '{1'b0, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0000, CHK};
    v[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, CHK};
    for (int i = 0; i < 17; i++) begin
      step(v[i].r, v[i].e, v[i].g);
      check($sformatf("vec%0d req", i), req, v[i].rq);
      check($sformatf("vec%0d served", i), served, v[i].sv);
      check($sformatf("vec%0d overflow", i), overflow, v[i].ov);
      check($sformatf("vec%0d grant_err", i), {3'b0, grant_err}, {3'b0, v[i].er});
    end
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 4'b0100, 4'b0000);
      if (k == 7) check("fill7 overflow", overflow, 4'b0000);
      if (k == 8) check("fill8 overflow", overflow, 4'b0100);
    end
    check("fill req", req, 4'b0100);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 4'b0000, 4'b0100);
      check($sformatf("drain%0d served", k), served, 4'b0100);
      check($sformatf("drain%0d gap req", k), req, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000);
      check($sformatf("drain%0d served off", k), served, 4'b0000);
      check($sformatf("drain%0d req", k), req, k < 6 ? 4'b0100 : 4'b0000);
    end
    step(1'b0, 4'b0000, 4'b0100);
    check("drained served", served, 4'b0000);
    check("drained overflow", overflow, 4'b0100);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0011, 4'b0000);
    check("pend req", req, 4'b0011);
    step(1'b1, 4'b0011, 4'b0011);
    check("rst req", req, 4'b0000);
    check("rst served", served, 4'b0000);
    check("rst overflow", overflow, 4'b0000);
    check("rst grant_err", {3'b0, grant_err}, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0000, 4'b0000);
      check($sformatf("post rst%0d req", k), req, 4'b0000);
    end
    step(1'b0, 4'b0001, 4'b0000);
    check("restart req", req, 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_request_issuer.md
ARB_REQUEST_ISSUER -- requirements
Module: arb_request_issuer

Interface
REQ-001 Parameter CNT_W, default 3, sets per-channel pending counter width; max pending per channel = 2^CNT_W-1 (7).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 evt  input  4  per-channel request event; each cycle high on bit i = one new transaction queued for channel i.
REQ-005 req  output  4  request to fixed-order arbiter, bit i = channel i; registered.
REQ-006 grant  input  4  arbiter grant, one cycle per served transaction, expected one-hot or zero.
REQ-007 served  output  4  one-cycle pulse, channel i transaction granted; registered.
REQ-008 overflow  output  4  sticky, channel i dropped an event because counter was full.
REQ-009 grant_err  output  1  sticky protocol error flag (see Configuration).

Function
REQ-010 Each channel SHALL have an independent CNT_W-bit pending counter and 3-state FSM: IDLE, REQ, GAP.
REQ-011 IDLE: req[i]=0, cnt=0; evt[i]=1 -> cnt=1, state REQ; req[i]=1 from next cycle (evt-to-req latency 1 cycle).
REQ-012 REQ: req[i]=1; grant[i]=1 sampled -> cnt decrements, served[i]=1 next cycle, state GAP.
REQ-013 GAP: req[i]=0 for exactly one cycle; then REQ if cnt>0, else IDLE.
REQ-014 evt[i] in any state SHALL increment cnt, except same-edge grant[i] accepted in REQ: net cnt unchanged.
REQ-015 evt[i] with cnt at max and no same-edge decrement SHALL be dropped, cnt unchanged, overflow[i] set until reset.
REQ-016 evt[i] arriving in GAP with cnt=0 after decrement SHALL move to REQ, not IDLE.
REQ-017 grant[i] while channel not in REQ SHALL be ignored: no decrement, no served pulse.
REQ-018 Multi-hot grant: every granted channel in REQ SHALL be served independently; no arbitration inside this block.
REQ-019 Counter arithmetic SHALL never wrap: no decrement below 0, no increment above max.
REQ-020 served SHALL be at most one cycle wide per grant; consecutive transactions on one channel SHALL be spaced at least 2 cycles (GAP).

Reset
REQ-021 rst=1 at a clock edge SHALL force all FSMs to IDLE, all counters 0, req=0, served=0, overflow=0, grant_err=0, regardless of pending work.
REQ-022 evt and grant SHALL be ignored on any edge where rst=1; pending transactions are discarded, not replayed.
REQ-023 First edge with rst=0 SHALL process evt/grant normally.

Configuration
REQ-024 Macro ARB_REQ_ISSUER_GRANT_CHECK_EN defined: grant_err SHALL set (sticky until reset) on grant to a channel not in REQ, or grant with more than one bit high.
REQ-025 Macro undefined: grant_err SHALL be constant 0 and checking logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 Reset then evt=4'b1011 one cycle -> next cycle req=4'b1011; grant=4'b0001 -> served=4'b0001 next cycle, req=4'b1010 for GAP then 4'b1010 held.
REQ-027 evt[2] pulsed 9 cycles with no grant -> cnt=7, overflow=4'b0100, then 7 grants (respecting GAP) produce 7 served pulses, req[2] falls after 7th.
REQ-028 Channel 3 cnt=1 in REQ, evt[3] and grant[3] same cycle -> cnt stays 1, served[3] pulses, req[3] low one cycle then high again.
REQ-029 grant=4'b0100 with req=4'b0000 -> no served; grant_err=1 with macro, 0 without; grant=4'b0011 -> grant_err=1 with macro.
REQ-030 cnt=3 on channels 0 and 1, rst asserted one cycle mid-sequence -> req=0, served=0, overflow=0 next cycle; no requests reappear without new evt.
